// File: rtl/mem_if_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_if_pkg                                                           |
// | Shared widths and state encoding for the backing-memory responder.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mem_if_pkg;

  localparam int MEM_ADDR_BITS = 26;
  localparam int MEM_TAG_BITS  = 5;
  localparam int MEM_DATA_BITS = 128;
  localparam int REFILL_CYCLES = 4;
  localparam int BEAT_BITS     = $clog2(REFILL_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_responder_ram.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_responder_ram                                                    |
// | Single-port synchronous RAM, one-cycle read latency, no reset.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_responder_ram #(
  parameter int WORDS     = 1024,
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 128
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] r_mem [WORDS];

  // Read-before-write; the responder never reads and writes in one cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_responder                                                        |
// | Line-based memory target: absorbs write beats, returns tagged reads. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mem_responder #(
  parameter int MEM_ADDR_BITS = mem_if_pkg::MEM_ADDR_BITS,
  parameter int MEM_TAG_BITS  = mem_if_pkg::MEM_TAG_BITS,
  parameter int MEM_DATA_BITS = mem_if_pkg::MEM_DATA_BITS,
  parameter int REFILL_CYCLES = mem_if_pkg::REFILL_CYCLES,
  parameter int DEPTH_LINES   = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_req_cmd_valid,
  output logic                     mem_req_cmd_ready,
  input  logic                     mem_req_cmd_bits_rw,
  input  logic [MEM_ADDR_BITS-1:0] mem_req_cmd_bits_addr,
  input  logic [MEM_TAG_BITS-1:0]  mem_req_cmd_bits_tag,
  input  logic                     mem_req_data_valid,
  output logic                     mem_req_data_ready,
  input  logic [MEM_DATA_BITS-1:0] mem_req_data_bits_data,
  output logic                     mem_resp_valid,
  input  logic                     mem_resp_ready,
  output logic [MEM_TAG_BITS-1:0]  mem_resp_bits_tag,
  output logic [MEM_DATA_BITS-1:0] mem_resp_bits_data
);

  // Derived from this instance's parameters so overrides stay consistent.
  localparam int C_BEAT_BITS = $clog2(REFILL_CYCLES);
  localparam int C_LINE_BITS = $clog2(DEPTH_LINES);
  localparam int C_RAM_BITS  = C_LINE_BITS + C_BEAT_BITS;
  localparam int C_RAM_WORDS = DEPTH_LINES * REFILL_CYCLES;
  localparam logic [C_BEAT_BITS-1:0] C_LAST_BEAT = C_BEAT_BITS'(REFILL_CYCLES - 1);

  import mem_if_pkg::*;

  state_t                   r_state;
  logic [C_BEAT_BITS-1:0]   r_cnt;
  logic [C_LINE_BITS-1:0]   r_line;
  logic [MEM_TAG_BITS-1:0]  r_tag;
  logic                     r_resp_valid;

  logic                     w_cmd_fire;
  logic                     w_data_fire;
  logic                     w_resp_fire;
  logic                     w_last;
  logic                     w_ram_we;
  logic [C_LINE_BITS-1:0]   w_ram_line;
  logic [C_BEAT_BITS-1:0]   w_ram_beat;
  logic [C_RAM_BITS-1:0]    w_ram_addr;
  logic [MEM_DATA_BITS-1:0] w_rdata;
  logic [C_LINE_BITS-1:0]   w_cmd_line;

  assign w_cmd_line  = mem_req_cmd_bits_addr[C_LINE_BITS-1:0];

  // Upper address bits alias away; they are intentionally dropped.
  generate
    if (MEM_ADDR_BITS > C_LINE_BITS) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^mem_req_cmd_bits_addr[MEM_ADDR_BITS-1:C_LINE_BITS];
    end
  endgenerate

  // cmd_ready must read low for the whole reset window, not only after an edge.
  assign mem_req_cmd_ready  = (r_state == IDLE) & ~reset;
  assign mem_req_data_ready = (r_state == WRITE);
  assign mem_resp_valid     = r_resp_valid;
  assign mem_resp_bits_tag  = r_tag;
  assign mem_resp_bits_data = r_resp_valid ? w_rdata : '0;

  assign w_cmd_fire  = mem_req_cmd_valid & mem_req_cmd_ready;
  assign w_data_fire = mem_req_data_valid & mem_req_data_ready;
  assign w_resp_fire = r_resp_valid & mem_resp_ready;
  assign w_last      = (r_cnt == C_LAST_BEAT);

  // The RAM output is the response register, so in READ the address is held
  // on the presented beat until it fires, which keeps rdata stable.
  always_comb begin
    w_ram_we   = 1'b0;
    w_ram_line = r_line;
    w_ram_beat = r_cnt;
    case (r_state)
      IDLE: begin
        w_ram_line = w_cmd_line;
        w_ram_beat = '0;
      end
      WRITE: begin
        w_ram_we = w_data_fire;
      end
      READ: begin
        if (w_resp_fire && !w_last) begin
          w_ram_beat = r_cnt + 1'b1;
        end
      end
      default: begin
        w_ram_we = 1'b0;
      end
    endcase
  end

  assign w_ram_addr = {w_ram_line, w_ram_beat};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_line       <= '0;
      r_tag        <= '0;
      r_resp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cmd_fire) begin
            r_line <= w_cmd_line;
            r_tag  <= mem_req_cmd_bits_tag;
            r_cnt  <= '0;
            if (mem_req_cmd_bits_rw) begin
              r_state <= WRITE;
            end else begin
              r_state      <= READ;
              r_resp_valid <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (w_data_fire) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= IDLE;
            end
          end
        end
        READ: begin
          if (w_resp_fire) begin
            if (w_last) begin
              r_state      <= IDLE;
              r_resp_valid <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state      <= IDLE;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  mem_responder_ram #(
    .WORDS     (C_RAM_WORDS),
    .ADDR_BITS (C_RAM_BITS),
    .DATA_BITS (MEM_DATA_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (mem_req_data_bits_data),
    .rdata (w_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_responder                                                     |
// | Directed stimulus with a queue-based response scoreboard.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mem_responder;
  import mem_if_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     cmd_valid = 1'b0;
  logic                     cmd_ready;
  logic                     cmd_rw = 1'b0;
  logic [MEM_ADDR_BITS-1:0] cmd_addr = '0;
  logic [MEM_TAG_BITS-1:0]  cmd_tag = '0;
  logic                     data_valid = 1'b0;
  logic                     data_ready;
  logic [MEM_DATA_BITS-1:0] data_in = '0;
  logic                     resp_valid;
  logic                     resp_ready = 1'b1;
  logic [MEM_TAG_BITS-1:0]  resp_tag;
  logic [MEM_DATA_BITS-1:0] resp_data;

  mem_responder dut (
    .clk                    (clk),
    .reset                  (reset),
    .mem_req_cmd_valid      (cmd_valid),
    .mem_req_cmd_ready      (cmd_ready),
    .mem_req_cmd_bits_rw    (cmd_rw),
    .mem_req_cmd_bits_addr  (cmd_addr),
    .mem_req_cmd_bits_tag   (cmd_tag),
    .mem_req_data_valid     (data_valid),
    .mem_req_data_ready     (data_ready),
    .mem_req_data_bits_data (data_in),
    .mem_resp_valid         (resp_valid),
    .mem_resp_ready         (resp_ready),
    .mem_resp_bits_tag      (resp_tag),
    .mem_resp_bits_data     (resp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [MEM_TAG_BITS-1:0]  tag;
    logic [MEM_DATA_BITS-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    rd_seq = 0;
  int    rd_fire_cyc = 0;
  bit    tight = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_line(input logic [MEM_TAG_BITS-1:0] tag, input logic [MEM_DATA_BITS-1:0] base, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      exp_q.push_back('{tag: tag, data: base + MEM_DATA_BITS'(b)});
    end
  endtask

  // Returns at 1ns after the accepting edge; fire_cyc is that edge's count.
  task automatic send_cmd(input logic rw, input logic [MEM_ADDR_BITS-1:0] addr,
                          input logic [MEM_TAG_BITS-1:0] tag, output int fire_cyc);
    int n;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_tag = tag;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 50);
    chk("cmd_accept", cmd_ready, 1'b1);
    fire_cyc = cyc + 1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic write_beats(input logic [MEM_DATA_BITS-1:0] base);
    int n;
    for (int b = 0; b < REFILL_CYCLES; b++) begin
      data_valid = 1'b1;
      data_in = base + MEM_DATA_BITS'(b);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!data_ready && n < 50);
      chk("data_accept", data_ready, 1'b1);
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
  endtask

  task automatic write_line(input logic [MEM_ADDR_BITS-1:0] addr, input logic [MEM_TAG_BITS-1:0] tag,
                            input logic [MEM_DATA_BITS-1:0] base);
    int fc;
    send_cmd(1'b1, addr, tag, fc);
    write_beats(base);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic read_line(input logic [MEM_ADDR_BITS-1:0] addr, input logic [MEM_TAG_BITS-1:0] tag,
                           input logic [MEM_DATA_BITS-1:0] base, input bit is_tight);
    int fc;
    push_line(tag, base, REFILL_CYCLES);
    tight = is_tight;
    send_cmd(1'b0, addr, tag, fc);
    rd_fire_cyc = fc;
    rd_seq++;
    drain();
  endtask

  // Monitor: compares every fired response beat against the scoreboard.
  int    mon_seq = 0;
  int    beat = 0;
  logic  pv = 1'b0;
  logic  pr = 1'b0;
  logic [MEM_TAG_BITS-1:0]  ptag = '0;
  logic [MEM_DATA_BITS-1:0] pdata = '0;
  beat_t e;

  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (mon_seq != rd_seq) begin
        mon_seq = rd_seq;
        beat = 0;
        chk("first_beat_latency", cyc, rd_fire_cyc);
      end
      if (pv && !pr) begin
        chk("hold_data", resp_data, pdata);
        chk("hold_tag", resp_tag, ptag);
      end
      if (resp_ready) begin
        chk("beat_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("resp_tag", resp_tag, e.tag);
          chk("resp_data", resp_data, e.data);
        end
        if (tight && beat == REFILL_CYCLES - 1) begin
          chk("last_beat_latency", cyc, rd_fire_cyc + REFILL_CYCLES - 1);
        end
        beat++;
      end
    end
    pv = resp_valid;
    pr = resp_ready;
    ptag = resp_tag;
    pdata = resp_data;
  end

  initial begin
    int fc;

    #12;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_data_ready", data_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_tag", resp_tag, 0);
    chk("rst_resp_data", resp_data, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1'b1);

    // Write then read with constant ready.
    write_line(26'h10, 5'd3, 128'hA0);
    read_line(26'h10, 5'd5, 128'hA0, 1'b1);

    // Backpressure on beat 1 for three cycles.
    push_line(5'd5, 128'hA0, REFILL_CYCLES);
    tight = 1'b0;
    send_cmd(1'b0, 26'h10, 5'd5, fc);
    rd_fire_cyc = fc;
    rd_seq++;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resp_ready = 1'b1;
    drain();

    // Write data offered in IDLE must be refused and leave RAM untouched.
    data_valid = 1'b1;
    data_in = 128'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("early_data_ready", data_ready, 1'b0);
    end
    @(posedge clk); #1;
    data_valid = 1'b0;
    read_line(26'h10, 5'd6, 128'hA0, 1'b1);

    // 0x110 aliases onto line 0x010.
    write_line(26'h110, 5'd4, 128'hB0);
    read_line(26'h010, 5'd7, 128'hB0, 1'b1);

    // Reset while beat 2 is presented.
    push_line(5'd7, 128'hB0, 2);
    tight = 1'b0;
    send_cmd(1'b0, 26'h10, 5'd7, fc);
    rd_fire_cyc = fc;
    rd_seq++;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_resp_valid", resp_valid, 1'b0);
    chk("midrst_cmd_ready", cmd_ready, 1'b0);
    chk("midrst_resp_data", resp_data, 0);
    chk("midrst_resp_tag", resp_tag, 0);
    chk("midrst_beats_seen", exp_q.size(), 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_cmd_ready", cmd_ready, 1'b1);
    read_line(26'h10, 5'd8, 128'hB0, 1'b1);

    // Read command followed immediately by a queued write command.
    push_line(5'd9, 128'hB0, REFILL_CYCLES);
    tight = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 26'h10; cmd_tag = 5'd9;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!cmd_ready && n < 50);
      chk("b2b_read_accept", cmd_ready, 1'b1);
    end
    fc = cyc + 1;
    @(posedge clk); #1;
    rd_fire_cyc = fc;
    rd_seq++;
    cmd_rw = 1'b1; cmd_addr = 26'h30; cmd_tag = 5'd1;
    for (int k = 0; k < REFILL_CYCLES; k++) begin
      @(negedge clk);
      chk("b2b_cmd_busy", cmd_ready, 1'b0);
    end
    @(negedge clk);
    chk("b2b_cmd_ready_again", cmd_ready, 1'b1);
    chk("b2b_read_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    write_beats(128'hC0);
    read_line(26'h30, 5'd2, 128'hC0, 1'b1);
    read_line(26'h10, 5'd10, 128'hB0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
